// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID register, MIPS delay-slot branch redirect and flush.
// Optional macro FETCH_ADEL_EN: misaligned PCs produce an address-error entry instead of a fetch.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        adel_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        redir_pend_r, redir_pend_s;
    logic [31:0] redir_pc_r, redir_pc_s;
    logic        drop_r, drop_s;
    logic        hb_valid_r, hb_valid_s;
    logic [31:0] hb_pc_r, hb_pc_s;
    logic [31:0] hb_inst_r, hb_inst_s;
    logic        hb_adel_r, hb_adel_s;
    logic        valid_r, valid_s;
    logic [31:0] pc_out_r, pc_out_s;
    logic [31:0] inst_r, inst_s;
    logic        adel_r, adel_s;

    logic        in_req_s;
    logic        req_s;
    logic        fetch_done_s;
    logic [31:0] fetch_inst_s;
    logic        fetch_adel_s;
    logic        consume_s;
    logic        slot_free_s;
    logic        branch_acc_s;
    logic [31:0] pc_adv_s;

    assign in_req_s = (state_r == ST_REQ);

`ifdef FETCH_ADEL_EN
    logic misalign_s;
    assign misalign_s   = (pc_r[1:0] != 2'b00);
    // While a dropped request is still outstanding the bus must see it through to its ack.
    assign req_s        = in_req_s && (drop_r || !misalign_s);
    assign fetch_done_s = in_req_s && !drop_r && (misalign_s || inst_ack_i);
    assign fetch_inst_s = misalign_s ? 32'h0000_0000 : inst_rdata_i;
    assign fetch_adel_s = misalign_s;
    assign inst_addr_o  = pc_r;
`else
    assign req_s        = in_req_s;
    assign fetch_done_s = in_req_s && !drop_r && inst_ack_i;
    assign fetch_inst_s = inst_rdata_i;
    assign fetch_adel_s = 1'b0;
    assign inst_addr_o  = {pc_r[31:2], 2'b00};
`endif

    assign consume_s    = valid_r && !stall_i;
    assign slot_free_s  = !valid_r || !stall_i;
    assign branch_acc_s = consume_s && branch_flag_i;
    assign pc_adv_s     = redir_pend_r ? redir_pc_r : (pc_r + 32'd4);

    assign inst_req_o = req_s;
    assign pc_o       = pc_out_r;
    assign inst_o     = inst_r;
    assign valid_o    = valid_r;
    assign adel_o     = adel_r;

    // Next-state computation for the fetch FSM, PC, redirect, hold buffer and IF/ID.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        redir_pend_s = redir_pend_r;
        redir_pc_s   = redir_pc_r;
        drop_s       = drop_r;
        hb_valid_s   = hb_valid_r;
        hb_pc_s      = hb_pc_r;
        hb_inst_s    = hb_inst_r;
        hb_adel_s    = hb_adel_r;
        pc_out_s     = pc_out_r;
        if (consume_s) begin
            valid_s = 1'b0;
            inst_s  = 32'h0000_0000;
            adel_s  = 1'b0;
        end else begin
            valid_s = valid_r;
            inst_s  = inst_r;
            adel_s  = adel_r;
        end

        if (flush_i) begin
            pc_s         = new_pc_i;
            valid_s      = 1'b0;
            inst_s       = 32'h0000_0000;
            adel_s       = 1'b0;
            hb_valid_s   = 1'b0;
            redir_pend_s = 1'b0;
            state_s      = ST_REQ;
            drop_s       = req_s && !inst_ack_i;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_REQ;
                end
                ST_REQ: begin
                    drop_s = drop_r && !inst_ack_i;
                    if (fetch_done_s) begin
                        // A branch accepted now makes this word its delay slot: jump straight on.
                        pc_s         = branch_acc_s ? branch_target_address_i : pc_adv_s;
                        redir_pend_s = 1'b0;
                        if (slot_free_s) begin
                            valid_s  = 1'b1;
                            pc_out_s = pc_r;
                            inst_s   = fetch_inst_s;
                            adel_s   = fetch_adel_s;
                        end else begin
                            hb_valid_s = 1'b1;
                            hb_pc_s    = pc_r;
                            hb_inst_s  = fetch_inst_s;
                            hb_adel_s  = fetch_adel_s;
                            state_s    = ST_HOLD;
                        end
                    end else if (branch_acc_s) begin
                        redir_pend_s = 1'b1;
                        redir_pc_s   = branch_target_address_i;
                    end else begin
                        redir_pend_s = redir_pend_r;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        valid_s    = hb_valid_r;
                        pc_out_s   = hb_pc_r;
                        inst_s     = hb_inst_r;
                        adel_s     = hb_adel_r;
                        hb_valid_s = 1'b0;
                        state_s    = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                    // The held word is the delay slot, so the target replaces pc at once.
                    if (branch_acc_s) begin
                        pc_s = branch_target_address_i;
                    end else begin
                        pc_s = pc_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            redir_pend_r <= 1'b0;
            redir_pc_r   <= 32'h0000_0000;
            drop_r       <= 1'b0;
            hb_valid_r   <= 1'b0;
            hb_pc_r      <= 32'h0000_0000;
            hb_inst_r    <= 32'h0000_0000;
            hb_adel_r    <= 1'b0;
            valid_r      <= 1'b0;
            pc_out_r     <= 32'h0000_0000;
            inst_r       <= 32'h0000_0000;
            adel_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            redir_pend_r <= redir_pend_s;
            redir_pc_r   <= redir_pc_s;
            drop_r       <= drop_s;
            hb_valid_r   <= hb_valid_s;
            hb_pc_r      <= hb_pc_s;
            hb_inst_r    <= hb_inst_s;
            hb_adel_r    <= hb_adel_s;
            valid_r      <= valid_s;
            pc_out_r     <= pc_out_s;
            inst_r       <= inst_s;
            adel_r       <= adel_s;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios, then randomized traffic checked
// against an instruction-stream model (expected PC order incl. delay slots and flushes).
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = 32'h0;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        adel_o;

    int checks = 0;
    int errors = 0;
    int fixed_lat = 0;
    bit rand_lat = 1'b0;
    int lat_left = 0;

    // random-phase reference model
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          slot_pend;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          consumed;

    if_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i), .flush_i(flush_i),
        .new_pc_i(new_pc_i), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
        .inst_ack_i(inst_ack_i), .inst_rdata_i(inst_rdata_i), .pc_o(pc_o),
        .inst_o(inst_o), .valid_o(valid_o), .adel_o(adel_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic int pick_lat();
        return rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    endfunction

    // Memory: lat_left cycles of wait before acking the current request.
    assign inst_ack_i   = inst_req_o && (lat_left == 0);
    assign inst_rdata_i = mem_word(inst_addr_o);

    always @(posedge clk) begin
        if (rst) lat_left <= pick_lat();
        else if (inst_req_o) lat_left <= (lat_left == 0) ? pick_lat() : lat_left - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(input string tag, input logic [31:0] p);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_pc"}, pc_o, p);
        chk({tag, "_inst"}, inst_o, mem_word(p));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_pc_o"}, pc_o, 32'd0);
        chk({tag, "_inst"}, inst_o, 32'd0);
        chk({tag, "_adel"}, {31'd0, adel_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, inst_req_o}, 32'd0);
        chk({tag, "_addr"}, inst_addr_o, RST_PC);
    endtask

    // Leaves the bench at the negedge of cycle 0 (state IDLE, rst released).
    task automatic do_reset();
        rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Zero-wait fetch from reset
        fixed_lat = 0; rand_lat = 1'b0;
        do_reset();
        check_reset_vals("rst");
        @(negedge clk);
        chk("c1_req", {31'd0, inst_req_o}, 32'd1);
        chk("c1_addr", inst_addr_o, RST_PC);
        chk("c1_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk); expect_pc("zw0", RST_PC);
        @(negedge clk); expect_pc("zw1", RST_PC + 32'd4);
        @(negedge clk); expect_pc("zw2", RST_PC + 32'd8);

        // Stall for 3 edges while the next word is acked into the hold buffer
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req", {31'd0, inst_req_o}, 32'd0);
            chk("stall_pc", pc_o, RST_PC + 32'd8);
        end
        stall_i = 1'b0;
        @(negedge clk); expect_pc("rel0", RST_PC + 32'd12);
        @(negedge clk); expect_pc("rel1", RST_PC + 32'd16);
        @(negedge clk); expect_pc("rel2", RST_PC + 32'd20);

        // Branch at 0x100 with delay slot in flight
        flush_i = 1'b1; new_pc_i = 32'h0000_0100;
        @(negedge clk); flush_i = 1'b0;
        chk("br_fl_valid", {31'd0, valid_o}, 32'd0);
        chk("br_fl_addr", inst_addr_o, 32'h0000_0100);
        @(negedge clk); expect_pc("br0", 32'h0000_0100);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h0000_0200;
        @(negedge clk); branch_flag_i = 1'b0;
        expect_pc("br1", 32'h0000_0104);
        @(negedge clk); expect_pc("br2", 32'h0000_0200);

        // Same branch with the delay slot parked in the hold buffer
        flush_i = 1'b1; new_pc_i = 32'h0000_0100;
        @(negedge clk); flush_i = 1'b0;
        @(negedge clk); expect_pc("hb0", 32'h0000_0100);
        stall_i = 1'b1;
        @(negedge clk);
        chk("hb_req", {31'd0, inst_req_o}, 32'd0);
        stall_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h0000_0200;
        @(negedge clk); branch_flag_i = 1'b0;
        expect_pc("hb1", 32'h0000_0104);
        chk("hb_addr", inst_addr_o, 32'h0000_0200);
        @(negedge clk); expect_pc("hb2", 32'h0000_0200);

        // Flush during a 3-cycle memory wait: the late ack must be discarded
        fixed_lat = 2;
        do_reset();
        @(negedge clk);
        chk("fw_c1_ack", {31'd0, inst_ack_i}, 32'd0);
        @(negedge clk);
        flush_i = 1'b1; new_pc_i = 32'h8000_0180;
        @(negedge clk); flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fw_valid", {31'd0, valid_o}, 32'd0);
            chk("fw_addr", inst_addr_o, 32'h8000_0180);
            @(negedge clk);
        end
        expect_pc("fw_data", 32'h8000_0180);

        // Reset while the stage sits in HOLD
        fixed_lat = 0;
        do_reset();
        @(negedge clk);
        @(negedge clk); expect_pc("mr0", RST_PC);
        stall_i = 1'b1;
        @(negedge clk);
        chk("mr_hold_req", {31'd0, inst_req_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mr_rst");
        rst = 1'b0; stall_i = 1'b0;
        @(negedge clk);
        chk("mr_req", {31'd0, inst_req_o}, 32'd1);
        chk("mr_addr", inst_addr_o, RST_PC);
        @(negedge clk); expect_pc("mr1", RST_PC);

        // Misaligned redirect
        flush_i = 1'b1; new_pc_i = 32'h0000_1002;
        @(negedge clk); flush_i = 1'b0; stall_i = 1'b1;
`ifdef FETCH_ADEL_EN
        chk("adel_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        chk("adel_valid", {31'd0, valid_o}, 32'd1);
        chk("adel_flag", {31'd0, adel_o}, 32'd1);
        chk("adel_inst", inst_o, 32'd0);
        chk("adel_pc", pc_o, 32'h0000_1002);
`else
        chk("mis_addr", inst_addr_o, 32'h0000_1000);
        @(negedge clk);
        chk("mis_valid", {31'd0, valid_o}, 32'd1);
        chk("mis_adel", {31'd0, adel_o}, 32'd0);
        chk("mis_pc", pc_o, 32'h0000_1002);
        chk("mis_inst", inst_o, mem_word(32'h0000_1000));
`endif
        stall_i = 1'b0;

        // Randomized traffic against the instruction-stream model
        rand_lat = 1'b1;
        do_reset();
        exp_pc = RST_PC; slot_pend = 1'b0; prev_hold = 1'b0; prev_addr = 32'h0; consumed = 0;
        tgt = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!valid_o) chk("rnd_nop", inst_o, 32'd0);
            if (prev_hold) begin
                chk("rnd_req_stable", {31'd0, inst_req_o}, 32'd1);
                chk("rnd_addr_stable", inst_addr_o, prev_addr);
            end
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 60) == 0);
            new_pc_i = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
            branch_flag_i = !flush_i && !slot_pend && ($urandom_range(0, 4) == 0);
            branch_target_address_i = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
            if (valid_o && !stall_i && !flush_i) begin
                chk("rnd_pc", pc_o, exp_pc);
                chk("rnd_inst", inst_o, mem_word(exp_pc));
                chk("rnd_adel", {31'd0, adel_o}, 32'd0);
                consumed++;
                if (branch_flag_i) begin
                    tgt = branch_target_address_i;
                    exp_pc = exp_pc + 32'd4;
                    slot_pend = 1'b1;
                end else if (slot_pend) begin
                    exp_pc = tgt;
                    slot_pend = 1'b0;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (flush_i) begin
                exp_pc = new_pc_i;
                slot_pend = 1'b0;
            end
            prev_hold = inst_req_o && !inst_ack_i && !flush_i;
            prev_addr = inst_addr_o;
        end
        stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
        chk("rnd_progress", {31'd0, (consumed >= 200)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
